// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling, early return
// to IDLE at mid-stop-bit so back-to-back and slightly skewed frames are accepted.
module uart_rx_byte #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE,
  parameter int SAMPLE_POINT = BAUD_CNT_MAX / 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
  localparam logic [3:0]       BIT_START  = 4'd0;
  localparam logic [3:0]       BIT_STOP   = 4'd9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       sr_reg, sr_next;
  logic [7:0]       data_reg, data_next;
  logic             flag_reg, flag_next;
  logic             ferr_reg, ferr_next;

  logic rx_s1, rx_s2, rx_s3;
  logic fall;

  // Sync flops reset high so a line held low through reset looks like a fresh edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign fall = rx_s3 & ~rx_s2;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sr_reg       <= '0;
      data_reg     <= '0;
      flag_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      sr_reg       <= sr_next;
      data_reg     <= data_next;
      flag_reg     <= flag_next;
      ferr_reg     <= ferr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    sr_next       = sr_reg;
    data_next     = data_reg;
    flag_next     = 1'b0;
    ferr_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next    = RECV;
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
        end
      end
      RECV: begin
        if (baud_cnt_reg == CNT_LAST) begin
          baud_cnt_next = '0;
          bit_cnt_next  = bit_cnt_reg + 4'd1;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end

        if (baud_cnt_reg == CNT_SAMPLE) begin
          if (bit_cnt_reg == BIT_START) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (rx_s2) begin
              state_next    = IDLE;
              baud_cnt_next = '0;
              bit_cnt_next  = '0;
            end
          end else if (bit_cnt_reg == BIT_STOP) begin
            state_next    = IDLE;
            baud_cnt_next = '0;
            bit_cnt_next  = '0;
            if (rx_s2) begin
              flag_next = 1'b1;
              data_next = sr_reg;
            end else begin
              ferr_next = 1'b1;
            end
          end else begin
            sr_next = {rx_s2, sr_reg[7:1]};
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_data   = data_reg;
  assign rx_flag   = flag_reg;
  assign frame_err = ferr_reg;
  assign rx_busy   = (state_reg == RECV);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at 32 clocks per bit; a line driver with fractional
// bit timing and a queue of expected bytes serve as the reference.
module tb_uart_rx_byte;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 1_562_500;
  localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;   // 32
  localparam int SAMPLE    = BIT_CLKS / 2;           // 16
  localparam int NOMINAL   = BIT_CLKS * 100;         // bit length in 1/100 clock
  localparam int LATENCY   = 9 * BIT_CLKS + SAMPLE + 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       frame_err;
  logic       rx_busy;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int start_cyc = 0;
  int last_flag_cyc = 0;
  int flag_cnt = 0;
  int ferr_cnt = 0;
  int viol_cnt = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_flag  (rx_flag),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Strobe monitor on the falling edge: collects received bytes and strobe rule breaks.
  always @(negedge sys_clk) begin
    if (rx_flag) begin
      got_q.push_back(rx_data);
      flag_cnt = flag_cnt + 1;
      last_flag_cyc = cyc;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_flag && frame_err) viol_cnt = viol_cnt + 1;
    if ((rx_flag || frame_err) && prev_strobe) viol_cnt = viol_cnt + 1;
    prev_strobe = rx_flag || frame_err;
  end

  // Called 1 time unit after a rising edge; leaves the line at the last bit driven.
  task automatic send_frame(input logic [7:0] b, input int bit_x100, input logic stop, input int nbits);
    logic [9:0] bits;
    int prev_edge;
    int next_edge;
    bits = {stop, b, 1'b0};
    prev_edge = 0;
    start_cyc = cyc;
    for (int k = 0; k < nbits; k++) begin
      rx = bits[k];
      next_edge = ((k + 1) * bit_x100) / 100;
      repeat (next_edge - prev_edge) @(posedge sys_clk);
      #1;
      prev_edge = next_edge;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_flag !== 1'b0) begin n_err++; $display("FAIL reset_rx_flag: got %b want 0", rx_flag); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
    sys_rst_n = 1'b1;
    idle(8);
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_single_byte;
    int f0, e0;
    logic busy_mid;
    f0 = flag_cnt; e0 = ferr_cnt; got_q.delete();
    busy_mid = 1'b0;
    fork
      send_frame(8'hA5, NOMINAL, 1'b1, 10);
      begin
        repeat (100) @(posedge sys_clk);
        #1;
        busy_mid = rx_busy;
      end
    join
    idle(8);
    n_cmp++; if (busy_mid !== 1'b1) begin n_err++; $display("FAIL single_busy_mid: got %b want 1", busy_mid); end
    n_cmp++; if (flag_cnt - f0 != 1) begin n_err++; $display("FAIL single_flag_count: got %0d want 1", flag_cnt - f0); end
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin n_err++; $display("FAIL single_byte: got %0d bytes first %h want A5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL single_rx_data: got %h want A5", rx_data); end
    n_cmp++; if (ferr_cnt != e0) begin n_err++; $display("FAIL single_frame_err: got %0d want 0", ferr_cnt - e0); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", rx_busy); end
    n_cmp++; if ((last_flag_cyc - start_cyc) < LATENCY - 1 || (last_flag_cyc - start_cyc) > LATENCY + 1) begin
      n_err++; $display("FAIL single_latency: got %0d want %0d+-1", last_flag_cyc - start_cyc, LATENCY);
    end
    $display("test_single_byte: sent A5 rx_data=%h latency=%0d", rx_data, last_flag_cyc - start_cyc);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    int e0;
    e0 = ferr_cnt; got_q.delete();
    exp_q = '{8'h00, 8'hFF, 8'h55};
    foreach (exp_q[i]) send_frame(exp_q[i], NOMINAL, 1'b1, 10);
    idle(8);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (ferr_cnt != e0) begin n_err++; $display("FAIL b2b_frame_err: got %0d want 0", ferr_cnt - e0); end
    $display("test_back_to_back: 3 frames, %0d bytes received", got_q.size());
  endtask

  task automatic test_glitch;
    int f0, e0;
    f0 = flag_cnt; e0 = ferr_cnt;
    rx = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    rx = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_start: got %b want 1", rx_busy); end
    repeat (SAMPLE + 10) @(posedge sys_clk);
    #1;
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_drop: got %b want 0", rx_busy); end
    idle(2 * BIT_CLKS);
    n_cmp++; if (flag_cnt != f0 || ferr_cnt != e0) begin
      n_err++; $display("FAIL glitch_no_strobe: got flags %0d errs %0d want 0 0", flag_cnt - f0, ferr_cnt - e0);
    end
    got_q.delete();
    send_frame(8'h3C, NOMINAL, 1'b1, 10);
    idle(8);
    n_cmp++; if (got_q.size() != 1 || rx_data !== 8'h3C) begin n_err++; $display("FAIL glitch_next_frame: got %0d bytes rx_data %h want 1 3C", got_q.size(), rx_data); end
    $display("test_glitch: glitch ignored, next rx_data=%h", rx_data);
  endtask

  task automatic test_frame_err;
    int e0;
    e0 = ferr_cnt; got_q.delete();
    send_frame(8'h12, NOMINAL, 1'b1, 10);
    send_frame(8'h34, NOMINAL, 1'b0, 10);
    idle(2 * BIT_CLKS);
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h12) begin n_err++; $display("FAIL ferr_good_byte: got %0d bytes first %h want 1 12", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    n_cmp++; if (ferr_cnt - e0 != 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - e0); end
    n_cmp++; if (rx_data !== 8'h12) begin n_err++; $display("FAIL ferr_rx_data_hold: got %h want 12", rx_data); end
    $display("test_frame_err: rx_data=%h frame_err pulses=%0d", rx_data, ferr_cnt - e0);
  endtask

  task automatic test_break;
    int f0, e0;
    f0 = flag_cnt; e0 = ferr_cnt;
    rx = 1'b0;
    repeat (30 * BIT_CLKS) @(posedge sys_clk);
    #1;
    n_cmp++; if (ferr_cnt - e0 != 1 || flag_cnt != f0) begin
      n_err++; $display("FAIL break_single_err: got errs %0d flags %0d want 1 0", ferr_cnt - e0, flag_cnt - f0);
    end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL break_idle: got %b want 0", rx_busy); end
    // Reset released while the line is still low restarts one (bad) frame.
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (20 * BIT_CLKS) @(posedge sys_clk);
    #1;
    n_cmp++; if (ferr_cnt - e0 != 2 || flag_cnt != f0) begin
      n_err++; $display("FAIL break_after_reset: got errs %0d flags %0d want 2 0", ferr_cnt - e0, flag_cnt - f0);
    end
    idle(2 * BIT_CLKS);
    got_q.delete();
    send_frame(8'h81, NOMINAL, 1'b1, 10);
    idle(8);
    n_cmp++; if (got_q.size() != 1 || rx_data !== 8'h81) begin n_err++; $display("FAIL break_recover: got %0d bytes rx_data %h want 1 81", got_q.size(), rx_data); end
    $display("test_break: frame_err pulses=%0d, recovered rx_data=%h", ferr_cnt - e0, rx_data);
  endtask

  task automatic test_reset_mid_frame;
    int f0;
    f0 = flag_cnt;
    send_frame(8'hC3, NOMINAL, 1'b1, 5);
    rx = 1'b0;                 // bit D4 of C3
    repeat (SAMPLE) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (rx_data !== 8'h00 || rx_flag !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) begin
      n_err++; $display("FAIL midreset_outputs: got data %h flag %b err %b busy %b want 00 0 0 0", rx_data, rx_flag, frame_err, rx_busy);
    end
    repeat (3) @(posedge sys_clk);
    #1;
    rx = 1'b1;
    sys_rst_n = 1'b1;
    idle(2 * BIT_CLKS);
    n_cmp++; if (flag_cnt != f0) begin n_err++; $display("FAIL midreset_no_strobe: got %0d want 0", flag_cnt - f0); end
    got_q.delete();
    send_frame(8'h7E, NOMINAL, 1'b1, 10);
    idle(8);
    n_cmp++; if (got_q.size() != 1 || rx_data !== 8'h7E) begin n_err++; $display("FAIL midreset_next: got %0d bytes rx_data %h want 1 7E", got_q.size(), rx_data); end
    $display("test_reset_mid_frame: after reset rx_data=%h", rx_data);
  endtask

  task automatic test_throughput;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int e0, bad;
    e0 = ferr_cnt; got_q.delete(); bad = 0;
    for (int i = 0; i < 128; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, $urandom_range(NOMINAL * 98 / 100, NOMINAL * 102 / 100), 1'b1, 10);
    end
    idle(16);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; bad++;
        if (bad <= 8) $display("FAIL stream_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (ferr_cnt != e0) begin n_err++; $display("FAIL stream_frame_err: got %0d want 0", ferr_cnt - e0); end
    n_cmp++; if (viol_cnt != 0) begin n_err++; $display("FAIL strobe_rules: got %0d violations want 0", viol_cnt); end
    $display("test_throughput: %0d bytes sent with +-2%% skew, %0d received", exp_q.size(), got_q.size());
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid_frame();
    test_throughput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
